// File: rtl/mips_memory.sv
// mips_memory: word-addressed fetch/data memory with write-first forwarding, preload and sticky fault reporting
module mips_memory #(
  parameter int unsigned DEPTH = 1024,
  parameter logic [31:0] DATA_BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_addr,
  output logic [31:0] instruction,
  input  logic [31:0] data_addr,
  input  logic [31:0] write_data,
  input  logic        write_enable,
  output logic [31:0] read_data,
  input  logic        load_valid,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        fault,
  output logic [15:0] fault_count,
  output logic [31:0] fault_addr
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(DEPTH) << 2;
  logic [31:0] mem [DEPTH];
  logic [31:0] i_off, d_off, l_off;
  logic [AW-1:0] i_idx, d_idx, l_idx;
  logic i_ok, d_ok, l_ok, l_we, s_we, i_flt, d_flt;
  logic [16:0] sum;
  logic [31:0] instr_d, instr_q, rdata_d, rdata_q, faddr_d, faddr_q, prev_d, prev_q;
  logic [15:0] cnt_d, cnt_q;
  logic fault_d, fault_q;
  // decode addresses, resolve write collisions, forward same-edge writes and account faults
  always_comb begin
    i_off = instr_addr - DATA_BASE;
    d_off = data_addr - DATA_BASE;
    l_off = load_addr - DATA_BASE;
    i_idx = AW'(i_off >> 2);
    d_idx = AW'(d_off >> 2);
    l_idx = AW'(l_off >> 2);
    i_ok = i_off < SPAN && instr_addr[1:0] == 2'b00;
    d_ok = d_off < SPAN && data_addr[1:0] == 2'b00;
    l_ok = l_off < SPAN && load_addr[1:0] == 2'b00;
    l_we = load_valid && l_ok;
    s_we = write_enable && d_ok && !(l_we && l_idx == d_idx);
    instr_d = !i_ok ? 32'h0 : (l_we && l_idx == i_idx) ? load_data
            : (s_we && d_idx == i_idx) ? write_data : mem[i_idx];
    rdata_d = !d_ok ? 32'h0 : (l_we && l_idx == d_idx) ? load_data
            : s_we ? write_data : mem[d_idx];
    i_flt = !i_ok;
    d_flt = !d_ok && (write_enable || data_addr != prev_q);
    sum = {1'b0, cnt_q} + 17'(i_flt) + 17'(d_flt);
    cnt_d = sum[16] ? 16'hFFFF : sum[15:0];
    fault_d = fault_q || i_flt || d_flt;
    faddr_d = fault_q ? faddr_q : d_flt ? data_addr : i_flt ? instr_addr : faddr_q;
    prev_d = data_addr;
  end
  // storage is never reset so preloaded programs survive reset
  always_ff @(posedge clk) begin
    if (l_we) mem[l_idx] <= load_data;
    if (s_we) mem[d_idx] <= write_data;
  end
  // registered read ports and fault state
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= 32'h0;
      rdata_q <= 32'h0;
      fault_q <= 1'b0;
      cnt_q   <= 16'h0;
      faddr_q <= 32'h0;
      prev_q  <= 32'hFFFF_FFFF;
    end else begin
      instr_q <= instr_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
      faddr_q <= faddr_d;
      prev_q  <= prev_d;
    end
  end
  assign instruction = instr_q;
  assign read_data   = rdata_q;
  assign fault       = fault_q;
  assign fault_count = cnt_q;
  assign fault_addr  = faddr_q;
endmodule

// File: tb/tb_mips_memory.sv
// tb_mips_memory: directed vectors against hand-computed expectations for mips_memory
module tb_mips_memory;
  logic clk = 0, reset = 1;
  logic [31:0] instr_addr = 0, data_addr = 0, write_data = 0, load_addr = 0, load_data = 0;
  logic write_enable = 0, load_valid = 0;
  logic [31:0] instruction, read_data, fault_addr;
  logic [15:0] fault_count;
  logic fault;
  int errors = 0, checks = 0;
  mips_memory dut (
    .clk(clk), .reset(reset), .instr_addr(instr_addr), .instruction(instruction),
    .data_addr(data_addr), .write_data(write_data), .write_enable(write_enable),
    .read_data(read_data), .load_valid(load_valid), .load_addr(load_addr),
    .load_data(load_data), .fault(fault), .fault_count(fault_count), .fault_addr(fault_addr)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_instr"}, instruction, 0);
    chk({tag, "_rdata"}, read_data, 0);
    chk({tag, "_fault"}, 32'(fault), 0);
    chk({tag, "_cnt"}, 32'(fault_count), 0);
    chk({tag, "_faddr"}, fault_addr, 0);
  endtask
  logic [31:0] pre [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
  initial begin
    for (int i = 0; i < 4; i++) begin
      load_valid = 1; load_addr = 32'(i * 4); load_data = pre[i];
      step();
    end
    load_valid = 0;
    chk_zero("rst");
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      instr_addr = 32'(i * 4);
      step();
      chk($sformatf("fetch%0d", i), instruction, pre[i]);
    end
    data_addr = 32'h40; write_data = 32'hDEADBEEF; write_enable = 1; instr_addr = 32'h40;
    step();
    chk("st_fwd_data", read_data, 32'hDEADBEEF);
    chk("st_fwd_instr", instruction, 32'hDEADBEEF);
    write_enable = 0;
    step();
    chk("st_mem", read_data, 32'hDEADBEEF);
    load_valid = 1; load_addr = 32'h80; load_data = 32'hAAAA0000;
    write_enable = 1; data_addr = 32'h80; write_data = 32'h5555FFFF;
    step();
    chk("prio_fwd", read_data, 32'hAAAA0000);
    load_valid = 0; write_enable = 0;
    step();
    chk("prio_mem", read_data, 32'hAAAA0000);
    chk("prio_nofault", 32'(fault), 0);
    data_addr = 32'h42;
    step();
    chk("mis_rdata", read_data, 0);
    chk("mis_fault", 32'(fault), 1);
    chk("mis_cnt", 32'(fault_count), 1);
    data_addr = 32'd4096; write_enable = 1; write_data = 32'h00000BAD;
    step();
    chk("oor_rdata", read_data, 0);
    chk("oor_cnt", 32'(fault_count), 2);
    chk("oor_faddr", fault_addr, 32'h42);
    write_enable = 0; data_addr = 0;
    step();
    chk("oor_nowrite", read_data, 32'h11111111);
    chk("oor_cnt_hold", 32'(fault_count), 2);
    reset = 1;
    step();
    chk_zero("rst2");
    reset = 0; data_addr = 32'h42;
    for (int i = 0; i < 10; i++) step();
    chk("park_cnt", 32'(fault_count), 1);
    chk("park_faddr", fault_addr, 32'h42);
    reset = 1; data_addr = 32'h40; instr_addr = 32'h80;
    step();
    chk_zero("rst3");
    reset = 0;
    step();
    chk("keep_data", read_data, 32'hDEADBEEF);
    chk("keep_instr", instruction, 32'hAAAA0000);
    instr_addr = 32'h1; data_addr = 32'h43; write_enable = 1;
    for (int i = 0; i < 32767; i++) step();
    chk("sat_fffe", 32'(fault_count), 32'hFFFE);
    chk("sat_faddr", fault_addr, 32'h43);
    chk("sat_instr_nop", instruction, 0);
    step();
    chk("sat_ffff", 32'(fault_count), 32'hFFFF);
    step();
    chk("sat_hold", 32'(fault_count), 32'hFFFF);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
